id_ex_stage: RTL and testbench

//  ID/EX pipeline register fed by the register-file read ports and the decoder; feeds EX/ALU.

---
 rtl/id_ex_stage.sv | 135 +++++++++++++
 tb/tb_id_ex_stage.sv | 215 +++++++++++++++++++++
 2 files changed

// File: rtl/id_ex_stage.sv
// rtl/id_ex_stage.sv - ID/EX pipeline register with WB bypass and load-use bubble insertion
//
// Purpose:
//   Captures operands, immediate, register addresses and decoded control from ID each cycle
//   and presents them to EX. A WB write in the same cycle is bypassed into the captured
//   operands, because the register file writes at posedge and reads the old value.
//   A load in EX whose destination is a source of the ID instruction raises stall_o and
//   inserts one bubble.
//
// Optional feature:
//   ID_EX_PERF_EN - when defined, bubble_cnt_o counts load-use bubbles; otherwise it is 0.
//
// Ports:
//   clk_i, rst_i                  clock, asynchronous active-high reset
//   valid_i                       ID holds a real instruction
//   RSaddr_i, RTaddr_i, RDaddr_i  source/destination register addresses from ID
//   uses_rt_i                     ID instruction reads rt
//   RSdata_i, RTdata_i            register-file read data
//   imm_i, ctrl_i, mem_read_i     immediate, decoded control, load flag from ID
//   wb_we_i, wb_addr_i, wb_data_i WB register-file write
//   stall_i, flush_i              global freeze, squash of the ID instruction
//   stall_o                       load-use hazard, ID/IF must hold (combinational)
//   ex_*                          latched EX-side copies of the ID fields
//   bubble_cnt_o                  number of load-use bubbles inserted

module id_ex_stage #(
  parameter int DATA_W = 32,
  parameter int CTRL_W = 8
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              valid_i,
  input  logic [4:0]        RSaddr_i,
  input  logic [4:0]        RTaddr_i,
  input  logic              uses_rt_i,
  input  logic [4:0]        RDaddr_i,
  input  logic [DATA_W-1:0] RSdata_i,
  input  logic [DATA_W-1:0] RTdata_i,
  input  logic [DATA_W-1:0] imm_i,
  input  logic [CTRL_W-1:0] ctrl_i,
  input  logic              mem_read_i,
  input  logic              wb_we_i,
  input  logic [4:0]        wb_addr_i,
  input  logic [DATA_W-1:0] wb_data_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              stall_o,
  output logic              ex_valid_o,
  output logic [DATA_W-1:0] ex_rs_data_o,
  output logic [DATA_W-1:0] ex_rt_data_o,
  output logic [DATA_W-1:0] ex_imm_o,
  output logic [4:0]        ex_rs_addr_o,
  output logic [4:0]        ex_rt_addr_o,
  output logic [4:0]        ex_rd_addr_o,
  output logic [CTRL_W-1:0] ex_ctrl_o,
  output logic              ex_mem_read_o,
  output logic [31:0]       bubble_cnt_o
);

  logic [DATA_W-1:0] rs_sel;
  logic [DATA_W-1:0] rt_sel;

  // r0 always reads as zero, and a WB write to r0 must never leak through the bypass.
  always_comb begin
    rs_sel = RSdata_i;
    if (RSaddr_i == 5'd0)
      rs_sel = '0;
    else if (wb_we_i && (wb_addr_i == RSaddr_i))
      rs_sel = wb_data_i;
  end

  always_comb begin
    rt_sel = RTdata_i;
    if (RTaddr_i == 5'd0)
      rt_sel = '0;
    else if (wb_we_i && (wb_addr_i == RTaddr_i))
      rt_sel = wb_data_i;
  end

  assign stall_o = valid_i & ex_valid_o & ex_mem_read_o & (ex_rd_addr_o != 5'd0) &
                   ((ex_rd_addr_o == RSaddr_i) | (uses_rt_i & (ex_rd_addr_o == RTaddr_i)));

  // Flush outranks the global freeze so a squashed instruction never lingers in EX;
  // the freeze outranks the load-use bubble because the load itself is frozen too.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      ex_valid_o    <= 1'b0;
      ex_rs_data_o  <= '0;
      ex_rt_data_o  <= '0;
      ex_imm_o      <= '0;
      ex_rs_addr_o  <= '0;
      ex_rt_addr_o  <= '0;
      ex_rd_addr_o  <= '0;
      ex_ctrl_o     <= '0;
      ex_mem_read_o <= 1'b0;
    end else if (flush_i || (!stall_i && stall_o)) begin
      ex_valid_o    <= 1'b0;
      ex_rs_data_o  <= '0;
      ex_rt_data_o  <= '0;
      ex_imm_o      <= '0;
      ex_rs_addr_o  <= '0;
      ex_rt_addr_o  <= '0;
      ex_rd_addr_o  <= '0;
      ex_ctrl_o     <= '0;
      ex_mem_read_o <= 1'b0;
    end else if (!stall_i) begin
      ex_valid_o    <= valid_i;
      ex_rs_data_o  <= rs_sel;
      ex_rt_data_o  <= rt_sel;
      ex_imm_o      <= imm_i;
      ex_rs_addr_o  <= RSaddr_i;
      ex_rt_addr_o  <= RTaddr_i;
      ex_rd_addr_o  <= RDaddr_i;
      ex_ctrl_o     <= ctrl_i;
      ex_mem_read_o <= mem_read_i;
    end
  end

`ifdef ID_EX_PERF_EN
  logic [31:0] bubble_cnt_q;

  // Only genuine load-use bubbles are counted; a flush that coincides with a hazard is a flush.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i)
      bubble_cnt_q <= '0;
    else if (!flush_i && !stall_i && stall_o)
      bubble_cnt_q <= bubble_cnt_q + 32'd1;
  end

  assign bubble_cnt_o = bubble_cnt_q;
`else
  assign bubble_cnt_o = '0;
`endif

endmodule

// File: tb/tb_id_ex_stage.sv
// tb/tb_id_ex_stage.sv - randomized and directed bench for id_ex_stage against a reference model

module tb_id_ex_stage;

  logic        clk_i = 1'b0;
  logic        rst_i;
  logic        valid_i;
  logic [4:0]  RSaddr_i, RTaddr_i, RDaddr_i, wb_addr_i;
  logic        uses_rt_i, mem_read_i, wb_we_i, stall_i, flush_i;
  logic [31:0] RSdata_i, RTdata_i, imm_i, wb_data_i;
  logic [7:0]  ctrl_i;
  logic        stall_o, ex_valid_o, ex_mem_read_o;
  logic [31:0] ex_rs_data_o, ex_rt_data_o, ex_imm_o, bubble_cnt_o;
  logic [4:0]  ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o;
  logic [7:0]  ex_ctrl_o;

  int n_cmp = 0;
  int n_err = 0;

  // Reference state: what EX should hold, as a plain record.
  typedef struct {
    logic        valid;
    logic [31:0] rs, rt, imm;
    logic [4:0]  rsa, rta, rd;
    logic [7:0]  ctrl;
    logic        mr;
  } ex_rec_t;

  ex_rec_t     m;
  logic [31:0] m_cnt;

`ifdef ID_EX_PERF_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  id_ex_stage #(.DATA_W(32), .CTRL_W(8)) dut (
    .clk_i(clk_i), .rst_i(rst_i), .valid_i(valid_i),
    .RSaddr_i(RSaddr_i), .RTaddr_i(RTaddr_i), .uses_rt_i(uses_rt_i), .RDaddr_i(RDaddr_i),
    .RSdata_i(RSdata_i), .RTdata_i(RTdata_i), .imm_i(imm_i), .ctrl_i(ctrl_i),
    .mem_read_i(mem_read_i), .wb_we_i(wb_we_i), .wb_addr_i(wb_addr_i), .wb_data_i(wb_data_i),
    .stall_i(stall_i), .flush_i(flush_i), .stall_o(stall_o),
    .ex_valid_o(ex_valid_o), .ex_rs_data_o(ex_rs_data_o), .ex_rt_data_o(ex_rt_data_o),
    .ex_imm_o(ex_imm_o), .ex_rs_addr_o(ex_rs_addr_o), .ex_rt_addr_o(ex_rt_addr_o),
    .ex_rd_addr_o(ex_rd_addr_o), .ex_ctrl_o(ex_ctrl_o), .ex_mem_read_o(ex_mem_read_o),
    .bubble_cnt_o(bubble_cnt_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic ex_rec_t empty_rec();
    ex_rec_t r;
    r.valid = 0; r.rs = 0; r.rt = 0; r.imm = 0;
    r.rsa = 0; r.rta = 0; r.rd = 0; r.ctrl = 0; r.mr = 0;
    return r;
  endfunction

  // Value an instruction in ID actually sees for a source register.
  function automatic logic [31:0] operand(input logic [4:0] a, input logic [31:0] rf);
    if (a == 0) return 32'd0;
    if (wb_we_i && wb_addr_i == a) return wb_data_i;
    return rf;
  endfunction

  function automatic logic hazard();
    return valid_i && m.valid && m.mr && m.rd != 0 &&
           (m.rd == RSaddr_i || (uses_rt_i && m.rd == RTaddr_i));
  endfunction

  task automatic check_ex(input string pfx);
    check({pfx, ".valid"}, {31'd0, ex_valid_o}, {31'd0, m.valid});
    check({pfx, ".rs"}, ex_rs_data_o, m.rs);
    check({pfx, ".rt"}, ex_rt_data_o, m.rt);
    check({pfx, ".imm"}, ex_imm_o, m.imm);
    check({pfx, ".addr"}, {17'd0, ex_rs_addr_o, ex_rt_addr_o, ex_rd_addr_o},
          {17'd0, m.rsa, m.rta, m.rd});
    check({pfx, ".ctrl"}, {23'd0, ex_mem_read_o, ex_ctrl_o}, {23'd0, m.mr, m.ctrl});
    check({pfx, ".cnt"}, bubble_cnt_o, PERF ? m_cnt : 32'd0);
  endtask

  // Called shortly after a posedge with inputs already driven: checks stall_o, advances
  // the model through the next edge, then checks EX.
  task automatic cycle(input string pfx);
    logic hz;
    #2;
    hz = hazard();
    check({pfx, ".stall"}, {31'd0, stall_o}, {31'd0, hz});
    if (flush_i) m = empty_rec();
    else if (stall_i) ;
    else if (hz) begin m = empty_rec(); m_cnt++; end
    else begin
      m.valid = valid_i; m.rs = operand(RSaddr_i, RSdata_i); m.rt = operand(RTaddr_i, RTdata_i);
      m.imm = imm_i; m.rsa = RSaddr_i; m.rta = RTaddr_i; m.rd = RDaddr_i;
      m.ctrl = ctrl_i; m.mr = mem_read_i;
    end
    @(posedge clk_i); #1;
    check_ex(pfx);
  endtask

  task automatic quiet();
    valid_i = 0; RSaddr_i = 0; RTaddr_i = 0; RDaddr_i = 0; uses_rt_i = 0;
    RSdata_i = 0; RTdata_i = 0; imm_i = 0; ctrl_i = 0; mem_read_i = 0;
    wb_we_i = 0; wb_addr_i = 0; wb_data_i = 0; stall_i = 0; flush_i = 0;
  endtask

  task automatic instr(input logic [4:0] rs, input logic [4:0] rt, input logic urt,
                       input logic [4:0] rd, input logic ld);
    valid_i = 1; RSaddr_i = rs; RTaddr_i = rt; uses_rt_i = urt; RDaddr_i = rd; mem_read_i = ld;
    RSdata_i = $urandom; RTdata_i = $urandom; imm_i = $urandom; ctrl_i = 8'($urandom);
  endtask

  task automatic do_reset();
    rst_i = 1; #1;
    m = empty_rec(); m_cnt = 0;
    @(posedge clk_i); #1;
    rst_i = 0;
  endtask

  initial begin
    quiet();
    rst_i = 1;
    m = empty_rec(); m_cnt = 0;
    repeat (2) @(posedge clk_i);
    #1;
    check_ex("reset");
    check("reset.stall", {31'd0, stall_o}, 32'd0);
    rst_i = 0;

    // Mid-stream asynchronous reset
    instr(5'd1, 5'd2, 1, 5'd3, 0); ctrl_i = 8'hA5;
    cycle("pre_rst");
    quiet();
    #2; rst_i = 1; #1;
    check("async_rst.valid", {31'd0, ex_valid_o}, 32'd0);
    check("async_rst.ctrl", {24'd0, ex_ctrl_o}, 32'd0);
    m = empty_rec(); m_cnt = 0;
    check_ex("async_rst");
    @(posedge clk_i); #1; rst_i = 0;

    // WB bypass and r0
    instr(5'd5, 5'd6, 1, 5'd7, 0); RSdata_i = 32'h11111111;
    wb_we_i = 1; wb_addr_i = 5'd5; wb_data_i = 32'hDEADBEEF;
    cycle("bypass");
    check("bypass.rs_val", ex_rs_data_o, 32'hDEADBEEF);
    instr(5'd0, 5'd0, 1, 5'd7, 0); wb_addr_i = 5'd0; wb_data_i = 32'h1234;
    cycle("r0");
    check("r0.rs_val", ex_rs_data_o, 32'd0);
    wb_we_i = 0;

    // Load-use: lw r8 ; add r9,r2,r8
    instr(5'd1, 5'd0, 0, 5'd8, 1);
    cycle("lu_load");
    instr(5'd2, 5'd8, 1, 5'd9, 0);
    #2; check("lu.stall_hi", {31'd0, stall_o}, 32'd1);
    cycle("lu_bubble");
    check("lu.bubble_valid", {31'd0, ex_valid_o}, 32'd0);
    cycle("lu_consumer");
    check("lu.consumer_rd", {27'd0, ex_rd_addr_o}, 32'd9);
    check("lu.cnt", bubble_cnt_o, PERF ? 32'd1 : 32'd0);

    // Priority: flush with stall -> bubble; stall alone holds for three cycles
    instr(5'd3, 5'd4, 1, 5'd10, 0);
    cycle("pri_load");
    instr(5'd3, 5'd4, 1, 5'd11, 0); flush_i = 1; stall_i = 1;
    cycle("pri_flush_stall");
    flush_i = 0; stall_i = 0;
    instr(5'd3, 5'd4, 1, 5'd12, 1);
    cycle("pri_load2");
    for (int i = 0; i < 3; i++) begin
      instr(5'($urandom_range(0, 31)), 5'($urandom_range(0, 31)), 1, 5'd13, 0);
      wb_we_i = 1; wb_addr_i = 5'd3; wb_data_i = $urandom; stall_i = 1;
      cycle("pri_hold");
      check("pri_hold.rd", {27'd0, ex_rd_addr_o}, 32'd12);
    end
    quiet();
    cycle("pri_release");

    // Perf: three load-use pairs, a flush coinciding with a hazard, and a plain flush
    do_reset();
    for (int k = 0; k < 3; k++) begin
      instr(5'd1, 5'd2, 1, 5'd8, 1); cycle("perf_ld");
      instr(5'd8, 5'd2, 0, 5'd9, 0); cycle("perf_bub"); cycle("perf_use");
    end
    instr(5'd1, 5'd2, 1, 5'd8, 1); cycle("perf_ld4");
    instr(5'd8, 5'd2, 0, 5'd9, 0); flush_i = 1; cycle("perf_flush_hz");
    instr(5'd4, 5'd5, 1, 5'd6, 0); cycle("perf_flush");
    flush_i = 0;
    check("perf.cnt", bubble_cnt_o, PERF ? 32'd3 : 32'd0);

    // Random traffic on a small register window so hazards and bypasses are frequent
    for (int i = 0; i < 400; i++) begin
      instr(5'($urandom_range(0, 3)), 5'($urandom_range(0, 3)), 1'($urandom_range(0, 1)),
            5'($urandom_range(0, 3)), ($urandom_range(0, 9) < 4));
      valid_i = ($urandom_range(0, 9) != 0);
      wb_we_i = 1'($urandom_range(0, 1)); wb_addr_i = 5'($urandom_range(0, 3));
      wb_data_i = $urandom;
      stall_i = ($urandom_range(0, 99) < 15);
      flush_i = ($urandom_range(0, 99) < 10);
      cycle("rand");
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
